// File: rtl/femtorv_mem_arbiter.sv
// Two-master arbiter in front of a single FemtoRV32-style memory port.
// Each master request is latched, serialised onto the slave, and read data is returned through a per-master holding register.
module femtorv_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [31:0]           m0_wdata,
  input  logic [3:0]            m0_wmask,
  input  logic                  m0_rstrb,
  output logic [31:0]           m0_rdata,
  output logic                  m0_rbusy,
  output logic                  m0_wbusy,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [31:0]           m1_wdata,
  input  logic [3:0]            m1_wmask,
  input  logic                  m1_rstrb,
  output logic [31:0]           m1_rdata,
  output logic                  m1_rbusy,
  output logic                  m1_wbusy,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [31:0]           s_wdata,
  output logic [3:0]            s_wmask,
  output logic                  s_rstrb,
  input  logic [31:0]           s_rdata,
  input  logic                  s_rbusy,
  input  logic                  s_wbusy,
  output logic                  err_overrun
);

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    ISSUE = 3'b010,
    WAIT  = 3'b100
  } state_t;

  state_t state, state_next;

  logic                  grant, grant_next, last_grant;
  logic                  issue, done;
  logic [1:0]            pending, is_write, strobe;
  logic [ADDR_WIDTH-1:0] req_addr  [2];
  logic [31:0]           req_wdata [2];
  logic [3:0]            req_wmask [2];
  logic [31:0]           rdata     [2];
  logic [ADDR_WIDTH-1:0] in_addr   [2];
  logic [31:0]           in_wdata  [2];
  logic [3:0]            in_wmask  [2];

  assign in_addr[0]  = m0_addr;
  assign in_addr[1]  = m1_addr;
  assign in_wdata[0] = m0_wdata;
  assign in_wdata[1] = m1_wdata;
  assign in_wmask[0] = m0_wmask;
  assign in_wmask[1] = m1_wmask;

  // A nonzero wmask makes the strobe a write even if rstrb is also high.
  assign strobe = {m1_rstrb | (|m1_wmask), m0_rstrb | (|m0_wmask)};

  assign m0_rdata = rdata[0];
  assign m1_rdata = rdata[1];
  assign m0_rbusy = pending[0] & ~is_write[0];
  assign m0_wbusy = pending[0] &  is_write[0];
  assign m1_rbusy = pending[1] & ~is_write[1];
  assign m1_wbusy = pending[1] &  is_write[1];

  always_comb begin
    state_next = state;
    grant_next = grant;
    issue      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (|pending) begin
          issue      = 1'b1;
          state_next = ISSUE;
          if (pending == 2'b11) begin
            grant_next = FIXED_PRIO ? 1'b0 : ~last_grant;
          end else begin
            grant_next = pending[1];
          end
        end else begin
          state_next = IDLE;
        end
      end
      ISSUE: begin
        state_next = WAIT;
      end
      WAIT: begin
        if (!s_rbusy && !s_wbusy) begin
          done       = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = WAIT;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant       <= 1'b0;
      last_grant  <= 1'b0;
      s_addr      <= '0;
      s_wdata     <= 32'h0000_0000;
      s_wmask     <= 4'b0000;
      s_rstrb     <= 1'b0;
      pending     <= 2'b00;
      is_write    <= 2'b00;
      err_overrun <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        req_addr[i]  <= '0;
        req_wdata[i] <= 32'h0000_0000;
        req_wmask[i] <= 4'b0000;
        rdata[i]     <= 32'h0000_0000;
      end
    end else begin
      // Slave strobes are single-cycle pulses; address and data stay put until the next grant.
      if (issue) begin
        grant      <= grant_next;
        last_grant <= grant_next;
        s_addr     <= req_addr[grant_next];
        s_wdata    <= req_wdata[grant_next];
        s_wmask    <= is_write[grant_next] ? req_wmask[grant_next] : 4'b0000;
        s_rstrb    <= ~is_write[grant_next];
      end else begin
        s_wmask <= 4'b0000;
        s_rstrb <= 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        // Completion takes precedence, so a strobe on the completion edge is an overrun.
        if (done && (grant == i[0])) begin
          pending[i] <= 1'b0;
          if (!is_write[i]) begin
            rdata[i] <= s_rdata;
          end
        end else if (strobe[i] && !pending[i]) begin
          pending[i]   <= 1'b1;
          is_write[i]  <= |in_wmask[i];
          req_addr[i]  <= in_addr[i];
          req_wdata[i] <= in_wdata[i];
          req_wmask[i] <= in_wmask[i];
        end
        if (strobe[i] && pending[i]) begin
          err_overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_femtorv_mem_arbiter.sv
// Bench for femtorv_mem_arbiter: a transaction-level model with a behavioural slave checks every cycle,
// while per-scenario tasks add directed latency, ordering, overrun and reset checks.
module tb_femtorv_mem_arbiter;

  logic        clk, reset;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wmask, m1_wmask;
  logic        m0_rstrb, m1_rstrb;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wmask;
  logic        s_rstrb, s_rbusy, s_wbusy, err_overrun;

  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_addr, fp_s_wdata, fp_s_rdata;
  logic        fp_m0_rbusy, fp_m0_wbusy, fp_m1_rbusy, fp_m1_wbusy;
  logic [3:0]  fp_s_wmask;
  logic        fp_s_rstrb, fp_s_rbusy, fp_s_wbusy, fp_err;

  int n_cmp, n_bad;
  int force_wait;
  int grant_log[$];
  int fp_log[$];
  logic [31:0] mem [256];

  femtorv_mem_arbiter #(.ADDR_WIDTH(32), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .reset(reset),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
    .m0_rdata(m0_rdata), .m0_rbusy(m0_rbusy), .m0_wbusy(m0_wbusy),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
    .m1_rdata(m1_rdata), .m1_rbusy(m1_rbusy), .m1_wbusy(m1_wbusy),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wmask(s_wmask), .s_rstrb(s_rstrb),
    .s_rdata(s_rdata), .s_rbusy(s_rbusy), .s_wbusy(s_wbusy), .err_overrun(err_overrun)
  );

  femtorv_mem_arbiter #(.ADDR_WIDTH(32), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .reset(reset),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
    .m0_rdata(fp_m0_rdata), .m0_rbusy(fp_m0_rbusy), .m0_wbusy(fp_m0_wbusy),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
    .m1_rdata(fp_m1_rdata), .m1_rbusy(fp_m1_rbusy), .m1_wbusy(fp_m1_wbusy),
    .s_addr(fp_s_addr), .s_wdata(fp_s_wdata), .s_wmask(fp_s_wmask), .s_rstrb(fp_s_rstrb),
    .s_rdata(fp_s_rdata), .s_rbusy(fp_s_rbusy), .s_wbusy(fp_s_wbusy), .err_overrun(fp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state: one outstanding request per master, plus the slave transaction in flight.
  bit          pend[2], issued[2], rwr[2];
  int          scyc[2];
  logic [31:0] raddr[2], rwd[2], rdx[2];
  logic [3:0]  rwm[2];
  bit          errx, lastg, act, act_rd;
  int          act_m, icyc, done_cyc, free_cyc, mcyc;
  logic [31:0] act_val;

  initial begin
    bit el[2];
    bit exp_issue, obs_issue, st, ob_rb, ob_wb;
    int g, w;
    logic [7:0] idx;
    logic [31:0] ob_rd;
    mcyc = 0;
    forever begin
      @(negedge clk);
      mcyc++;
      if (reset) begin
        for (int m = 0; m < 2; m++) begin
          pend[m] = 1'b0; issued[m] = 1'b0; rdx[m] = 32'h0;
        end
        errx = 1'b0; lastg = 1'b0; act = 1'b0; free_cyc = 0;
        s_rbusy = 1'b0; s_wbusy = 1'b0;
      end else begin
        for (int m = 0; m < 2; m++) begin
          ob_rb = (m == 0) ? m0_rbusy : m1_rbusy;
          ob_wb = (m == 0) ? m0_wbusy : m1_wbusy;
          ob_rd = (m == 0) ? m0_rdata : m1_rdata;
          n_cmp++;
          if ({ob_rb, ob_wb} !== {pend[m] & ~rwr[m], pend[m] & rwr[m]}) begin
            n_bad++;
            $display("FAIL busy_m%0d cyc %0d: got r%0b w%0b expected r%0b w%0b", m, mcyc, ob_rb, ob_wb,
                     pend[m] & ~rwr[m], pend[m] & rwr[m]);
          end
          n_cmp++;
          if (ob_rd !== rdx[m]) begin
            n_bad++;
            $display("FAIL rdata_m%0d cyc %0d: got %h expected %h", m, mcyc, ob_rd, rdx[m]);
          end
          el[m] = pend[m] && !issued[m] && (scyc[m] <= mcyc - 2);
        end
        n_cmp++;
        if (err_overrun !== errx) begin
          n_bad++;
          $display("FAIL err_overrun cyc %0d: got %0b expected %0b", mcyc, err_overrun, errx);
        end
        exp_issue = !act && (mcyc >= free_cyc) && (el[0] || el[1]);
        obs_issue = s_rstrb || (s_wmask != 4'h0);
        n_cmp++;
        if (obs_issue !== exp_issue) begin
          n_bad++;
          $display("FAIL issue cyc %0d: got %0b expected %0b", mcyc, obs_issue, exp_issue);
        end
        if (obs_issue && exp_issue) begin
          if (el[0] && el[1]) g = dut.FIXED_PRIO ? 0 : int'(!lastg);
          else g = el[1] ? 1 : 0;
          n_cmp++;
          if ({s_addr, s_wdata, s_wmask, s_rstrb} !== {raddr[g], rwd[g], rwr[g] ? rwm[g] : 4'h0, !rwr[g]}) begin
            n_bad++;
            $display("FAIL slave_req cyc %0d: got a=%h d=%h m=%h r=%0b expected master %0d a=%h d=%h m=%h r=%0b",
                     mcyc, s_addr, s_wdata, s_wmask, s_rstrb, g, raddr[g], rwd[g],
                     rwr[g] ? rwm[g] : 4'h0, !rwr[g]);
          end
          lastg = g[0]; issued[g] = 1'b1; act = 1'b1; act_m = g; act_rd = !rwr[g]; icyc = mcyc;
          w = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
          done_cyc = mcyc + w + 1;
          idx = raddr[g][9:2];
          if (rwr[g]) begin
            for (int b = 0; b < 4; b++) if (rwm[g][b]) mem[idx][8*b +: 8] = rwd[g][8*b +: 8];
          end else begin
            act_val = mem[idx];
          end
          grant_log.push_back(g);
        end
        // Slave: busy for the chosen wait cycles, read data valid only on the completing cycle.
        s_rdata = $urandom; s_rbusy = 1'b0; s_wbusy = 1'b0;
        if (act) begin
          if (mcyc > icyc && mcyc < done_cyc) begin
            if (act_rd) s_rbusy = 1'b1; else s_wbusy = 1'b1;
          end else if (mcyc == done_cyc && act_rd) begin
            s_rdata = act_val;
          end
        end
        for (int m = 0; m < 2; m++) begin
          st = (m == 0) ? (m0_rstrb || m0_wmask != 4'h0) : (m1_rstrb || m1_wmask != 4'h0);
          if (st) begin
            if (pend[m]) errx = 1'b1;
            else begin
              pend[m] = 1'b1; issued[m] = 1'b0; scyc[m] = mcyc;
              raddr[m] = (m == 0) ? m0_addr : m1_addr;
              rwd[m]   = (m == 0) ? m0_wdata : m1_wdata;
              rwm[m]   = (m == 0) ? m0_wmask : m1_wmask;
              rwr[m]   = (rwm[m] != 4'h0);
            end
          end
        end
        if (act && mcyc == done_cyc) begin
          pend[act_m] = 1'b0;
          if (act_rd) rdx[act_m] = act_val;
          act = 1'b0;
          free_cyc = mcyc + 2;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset && (fp_s_rstrb || fp_s_wmask != 4'h0)) fp_log.push_back(int'(fp_s_addr[31]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int m, input logic rd, input logic [3:0] wm, input logic [31:0] a,
                         input logic [31:0] d);
    if (m == 0) begin
      m0_rstrb = rd; m0_wmask = wm; m0_addr = a; m0_wdata = d;
    end else begin
      m1_rstrb = rd; m1_wmask = wm; m1_addr = a; m1_wdata = d;
    end
  endtask

  task automatic clear_req(input int m);
    set_req(m, 1'b0, 4'h0, $urandom, $urandom);
  endtask

  task automatic start_random(input int m);
    int kind;
    logic [31:0] a;
    logic [3:0] wm;
    kind = int'($urandom_range(0, 3));
    a = {(m == 1), 21'h0, 8'($urandom), 2'b00};
    wm = (kind >= 2) ? 4'($urandom_range(1, 15)) : 4'h0;
    set_req(m, kind != 2, wm, a, $urandom);
  endtask

  function automatic logic busy_of(input int m);
    return (m == 0) ? (m0_rbusy | m0_wbusy) : (m1_rbusy | m1_wbusy);
  endfunction

  task automatic wait_idle(input string name, input int budget);
    int c;
    c = 0;
    while ((busy_of(0) || busy_of(1)) && c < budget) begin
      tick();
      c++;
    end
    n_cmp++;
    if (busy_of(0) || busy_of(1)) begin
      n_bad++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, budget);
    end
  endtask

  task automatic reset_dut();
    clear_req(0); clear_req(1);
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_req(0); clear_req(1);
    reset = 1'b1;
    tick(); tick();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({s_addr, s_wdata} !== 64'h0) begin
        n_bad++; $display("FAIL reset_s_addr_wdata: got %h %h expected 0", s_addr, s_wdata);
      end
      n_cmp++;
      if ({s_wmask, s_rstrb, m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy, err_overrun} !== 10'h0) begin
        n_bad++;
        $display("FAIL reset_ctrl: got wm=%h rs=%0b busy=%0b%0b%0b%0b err=%0b expected all 0", s_wmask, s_rstrb,
                 m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy, err_overrun);
      end
      n_cmp++;
      if ({m0_rdata, m1_rdata} !== 64'h0) begin
        n_bad++; $display("FAIL reset_rdata: got %h %h expected 0", m0_rdata, m1_rdata);
      end
      reset = 1'b0;
      tick();
    end
  endtask

  task automatic test_single_read();
    force_wait = 0;
    mem[64] = 32'hDEAD_BEEF;
    set_req(0, 1'b1, 4'h0, 32'h0000_0100, 32'h0);
    tick(); clear_req(0);
    n_cmp++;
    if (m0_rbusy !== 1'b1 || s_rstrb !== 1'b0) begin
      n_bad++; $display("FAIL read_c1: got rbusy=%0b s_rstrb=%0b expected 1 0", m0_rbusy, s_rstrb);
    end
    tick();
    n_cmp++;
    if (s_rstrb !== 1'b1 || s_addr !== 32'h0000_0100) begin
      n_bad++; $display("FAIL read_c2: got s_rstrb=%0b s_addr=%h expected 1 00000100", s_rstrb, s_addr);
    end
    tick();
    n_cmp++;
    if (s_rstrb !== 1'b0 || m0_rbusy !== 1'b1) begin
      n_bad++; $display("FAIL read_c3: got s_rstrb=%0b rbusy=%0b expected 0 1", s_rstrb, m0_rbusy);
    end
    tick();
    n_cmp++;
    if (m0_rbusy !== 1'b0 || m0_rdata !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL read_c4: got rbusy=%0b rdata=%h expected 0 deadbeef", m0_rbusy, m0_rdata);
    end
  endtask

  task automatic test_byte_write();
    force_wait = 3;
    set_req(1, 1'b0, 4'b0100, 32'h8000_0040, 32'h00AB_0000);
    tick(); clear_req(1);
    tick();
    n_cmp++;
    if (s_wmask !== 4'b0100 || s_wdata !== 32'h00AB_0000 || s_rstrb !== 1'b0) begin
      n_bad++; $display("FAIL write_c2: got wm=%b wd=%h rs=%0b expected 0100 00ab0000 0", s_wmask, s_wdata, s_rstrb);
    end
    tick();
    n_cmp++;
    if (s_wmask !== 4'b0000) begin
      n_bad++; $display("FAIL write_c3_wmask: got %b expected 0000", s_wmask);
    end
    tick(); tick(); tick();
    n_cmp++;
    if (m1_wbusy !== 1'b1) begin
      n_bad++; $display("FAIL write_c6_wbusy: got %0b expected 1", m1_wbusy);
    end
    tick();
    n_cmp++;
    if (m1_wbusy !== 1'b0 || m1_rdata !== 32'h0) begin
      n_bad++; $display("FAIL write_c7: got wbusy=%0b rdata=%h expected 0 00000000", m1_wbusy, m1_rdata);
    end
  endtask

  task automatic test_simultaneous();
    int r0, r1;
    reset_dut();
    force_wait = 0;
    r0 = -1; r1 = -1;
    set_req(0, 1'b1, 4'h0, 32'h0000_0010, 32'h0);
    set_req(1, 1'b1, 4'h0, 32'h8000_0020, 32'h0);
    tick(); clear_req(0); clear_req(1);
    for (int c = 1; c <= 12; c++) begin
      if (c == 2 || c == 5) begin
        n_cmp++;
        if (s_rstrb !== 1'b1 || s_addr !== ((c == 2) ? 32'h8000_0020 : 32'h0000_0010)) begin
          n_bad++; $display("FAIL simul_order_c%0d: got rs=%0b addr=%h", c, s_rstrb, s_addr);
        end
      end
      if (r0 < 0 && !m0_rbusy) r0 = c;
      if (r1 < 0 && !m1_rbusy) r1 = c;
      tick();
    end
    n_cmp++;
    if (r1 !== 4 || r0 !== 7) begin
      n_bad++; $display("FAIL simul_release: got m1 %0d m0 %0d expected 4 7", r1, r0);
    end
  endtask

  task automatic test_back_to_back();
    int cnt[2];
    int c;
    force_wait = -1;
    grant_log.delete();
    cnt[0] = 0; cnt[1] = 0; c = 0;
    while ((cnt[0] < 8 || cnt[1] < 8 || busy_of(0) || busy_of(1)) && c < 400) begin
      for (int m = 0; m < 2; m++) begin
        clear_req(m);
        if (!busy_of(m) && cnt[m] < 8 && (c == 0 || grant_log.size() > 0)) begin
          start_random(m);
          cnt[m]++;
        end
      end
      tick();
      c++;
    end
    clear_req(0); clear_req(1);
    n_cmp++;
    if (grant_log.size() !== 16) begin
      n_bad++; $display("FAIL b2b_count: got %0d grants expected 16", grant_log.size());
    end
    for (int i = 1; i < grant_log.size(); i++) begin
      n_cmp++;
      if (grant_log[i] == grant_log[i-1]) begin
        n_bad++; $display("FAIL b2b_alternate[%0d]: got master %0d twice, expected alternation", i, grant_log[i]);
      end
    end
  endtask

  task automatic test_pair_priority();
    reset_dut();
    force_wait = 0;
    grant_log.delete(); fp_log.delete();
    for (int r = 0; r < 4; r++) begin
      set_req(0, 1'b1, 4'h0, {24'h0, 8'($urandom & 32'hFC)}, 32'h0);
      set_req(1, 1'b1, 4'h0, {1'b1, 23'h0, 8'($urandom & 32'hFC)}, 32'h0);
      tick(); clear_req(0); clear_req(1);
      wait_idle("pair", 20);
    end
    n_cmp++;
    if (grant_log.size() !== 8 || fp_log.size() !== 8) begin
      n_bad++; $display("FAIL pair_count: got %0d/%0d expected 8/8", grant_log.size(), fp_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (grant_log[i] !== ((i % 2 == 0) ? 1 : 0)) begin
          n_bad++; $display("FAIL pair_rr[%0d]: got %0d expected %0d", i, grant_log[i], (i % 2 == 0) ? 1 : 0);
        end
        n_cmp++;
        if (fp_log[i] !== (i % 2)) begin
          n_bad++; $display("FAIL pair_fixed[%0d]: got %0d expected %0d", i, fp_log[i], i % 2);
        end
      end
    end
  endtask

  task automatic test_overrun();
    int n0;
    force_wait = 4;
    n0 = grant_log.size();
    set_req(0, 1'b1, 4'h0, 32'h0000_001C, 32'h0);
    tick(); clear_req(0);
    tick();
    n_cmp++;
    if (err_overrun !== 1'b0) begin
      n_bad++; $display("FAIL overrun_before: got %0b expected 0", err_overrun);
    end
    set_req(0, 1'b1, 4'h0, 32'h0000_0030, 32'h0);
    tick(); clear_req(0);
    n_cmp++;
    if (err_overrun !== 1'b1) begin
      n_bad++; $display("FAIL overrun_set: got %0b expected 1", err_overrun);
    end
    wait_idle("overrun", 30);
    n_cmp++;
    if (grant_log.size() !== n0 + 1 || err_overrun !== 1'b1) begin
      n_bad++; $display("FAIL overrun_drop: got %0d issues err=%0b expected %0d 1", grant_log.size() - n0, err_overrun, 1);
    end
    force_wait = 0;
    n0 = grant_log.size();
    set_req(0, 1'b1, 4'h0, 32'h0000_0024, 32'h0);
    tick(); clear_req(0);
    tick(); tick();
    set_req(0, 1'b1, 4'h0, 32'h0000_0028, 32'h0);
    tick(); clear_req(0);
    n_cmp++;
    if (m0_rbusy !== 1'b0) begin
      n_bad++; $display("FAIL same_edge_busy: got %0b expected 0", m0_rbusy);
    end
    repeat (5) tick();
    n_cmp++;
    if (grant_log.size() !== n0 + 1) begin
      n_bad++; $display("FAIL same_edge_drop: got %0d issues expected 1", grant_log.size() - n0);
    end
  endtask

  task automatic test_reset_mid();
    force_wait = 5;
    set_req(0, 1'b1, 4'h0, 32'h0000_000C, 32'h0);
    tick(); clear_req(0);
    tick(); tick(); tick();
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({s_rstrb, s_wmask, m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy, err_overrun} !== 10'h0) begin
      n_bad++;
      $display("FAIL reset_mid: got rs=%0b wm=%h busy=%0b%0b%0b%0b err=%0b expected all 0", s_rstrb, s_wmask,
               m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy, err_overrun);
    end
    tick(); tick();
    reset = 1'b0;
    force_wait = 0;
    set_req(0, 1'b1, 4'h0, 32'h0000_0014, 32'h0);
    tick(); clear_req(0);
    tick(); tick(); tick();
    n_cmp++;
    if (m0_rbusy !== 1'b0 || m0_rdata !== mem[5]) begin
      n_bad++; $display("FAIL reset_recover: got busy=%0b rdata=%h expected 0 %h", m0_rbusy, m0_rdata, mem[5]);
    end
  endtask

  task automatic test_random();
    force_wait = -1;
    for (int c = 0; c < 400; c++) begin
      for (int m = 0; m < 2; m++) begin
        clear_req(m);
        if (!busy_of(m) && $urandom_range(0, 2) == 0) start_random(m);
        else if (busy_of(m) && $urandom_range(0, 30) == 0) start_random(m);
      end
      tick();
    end
    clear_req(0); clear_req(1);
    wait_idle("random", 40);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; force_wait = 0;
    fp_s_rdata = 32'h0; fp_s_rbusy = 1'b0; fp_s_wbusy = 1'b0;
    s_rdata = 32'h0; s_rbusy = 1'b0; s_wbusy = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    reset = 1'b1;
    clear_req(0); clear_req(1);
    test_reset();
    test_single_read();
    test_byte_write();
    test_simultaneous();
    test_back_to_back();
    test_pair_priority();
    test_overrun();
    test_reset_mid();
    test_random();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
